uadder_collect: RTL and testbench

//  Result-side collector for the chunk-serial micro-adder in the microcoded core.
//  It accepts an operation tag from the microcode sequencer, then receives WADD-bit
//  sum/difference chunks, LSB chunk first, one per chunk_valid beat.
//  It assembles the WIDTH-bit result and resolves the branch/compare condition.
//  It returns result and condition to the sequencer over a valid/ready response port.

---
 rtl/uadder_collect.sv | 144 ++++++++++++++
 tb/tb_uadder_collect.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uadder_collect.sv
// Result-side collector for the chunk-serial micro-adder: assembles WIDTH-bit
// results from LSB-first chunks and resolves the compare condition.
module uadder_collect #(
    parameter int WIDTH = 32,
    parameter int WADD  = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic            req_a_sign,
    input  logic            req_b_sign,
    input  logic            chunk_valid,
    input  logic [WADD-1:0] chunk_data,
    input  logic            chunk_cout,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic            rsp_cond,
    output logic            rsp_cout,
    output logic            busy,
    output logic            proto_err,
    output logic [1:0]      state_dbg
);
    localparam int NCYC  = (WIDTH + WADD - 1) / WADD;
    localparam int WLAST = WIDTH - (NCYC - 1) * WADD;
    localparam int IW    = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [WADD-1:0] LAST_MASK = {WADD{1'b1}} >> (WADD - WLAST);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RESP    = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_EQ  = 3'b000,
        OP_NE  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_LT  = 3'b100,
        OP_GE  = 3'b101,
        OP_LTU = 3'b110,
        OP_GEU = 3'b111
    } adder_op_t;

    state_t          state;
    adder_op_t       op;
    logic            a_sign;
    logic            b_sign;
    logic [IW-1:0]   idx;
    logic [WIDTH-1:0] result;
    logic            zero;
    logic            cout;
    logic            cond;
    logic            err_q;

    logic            last_beat;
    logic [WADD-1:0] chunk_masked;
    logic            zero_next;
    logic            lt;
    logic            cond_next;

    always_comb begin
        last_beat    = (idx == IW'(NCYC - 1));
        chunk_masked = last_beat ? (chunk_data & LAST_MASK) : chunk_data;
        zero_next    = zero & (chunk_masked == '0);
        // Result MSB comes from the final chunk arriving this cycle.
        lt           = (a_sign != b_sign) ? a_sign : chunk_data[WLAST-1];
        cond_next    = 1'b0;
        case (op)
            OP_EQ:   cond_next = zero_next;
            OP_NE:   cond_next = ~zero_next;
            OP_LT:   cond_next = lt;
            OP_GE:   cond_next = ~lt;
            OP_LTU:  cond_next = ~chunk_cout;
            OP_GEU:  cond_next = chunk_cout;
            default: cond_next = 1'b0;
        endcase
    end

    // Both ports use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; the producer holds its payload until then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op     <= OP_ADD;
            a_sign <= 1'b0;
            b_sign <= 1'b0;
            idx    <= '0;
            result <= '0;
            zero   <= 1'b1;
            cout   <= 1'b0;
            cond   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (chunk_valid && state != COLLECT)
                err_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op     <= adder_op_t'(req_op);
                        a_sign <= req_a_sign;
                        b_sign <= req_b_sign;
                        idx    <= '0;
                        zero   <= 1'b1;
                        state  <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (chunk_valid) begin
                        zero <= zero_next;
                        for (int k = 0; k < NCYC - 1; k++)
                            if (idx == IW'(k))
                                result[k*WADD +: WADD] <= chunk_data;
                        if (last_beat) begin
                            result[WIDTH-1 -: WLAST] <= chunk_data[WLAST-1:0];
                            cout  <= chunk_cout;
                            cond  <= cond_next;
                            state <= RESP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign rsp_valid  = (state == RESP);
    assign rsp_result = result;
    assign rsp_cond   = cond;
    assign rsp_cout   = cout;
    assign proto_err  = err_q;
    assign state_dbg  = state;
endmodule

// File: tb/tb_uadder_collect.sv
// Directed bench for uadder_collect with WIDTH=32, WADD=12 (three chunks, 8-bit last).
module tb_uadder_collect;
    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic        req_a_sign;
    logic        req_b_sign;
    logic        chunk_valid;
    logic [11:0] chunk_data;
    logic        chunk_cout;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_cond;
    logic        rsp_cout;
    logic        busy;
    logic        proto_err;
    logic [1:0]  state_dbg;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] EQ = 3'b000, NE = 3'b001, ADD = 3'b010, SUB = 3'b011;
    localparam logic [2:0] LT = 3'b100, GE = 3'b101, LTU = 3'b110, GEU = 3'b111;

    uadder_collect #(.WIDTH(32), .WADD(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a_sign(req_a_sign), .req_b_sign(req_b_sign),
        .chunk_valid(chunk_valid), .chunk_data(chunk_data), .chunk_cout(chunk_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_cond(rsp_cond), .rsp_cout(rsp_cout), .busy(busy),
        .proto_err(proto_err), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue a request and three chunk beats back to back; leaves the DUT in RESP.
    task automatic run_op(input logic [2:0] op, input logic as, input logic bs,
                          input logic [11:0] c0, input logic [11:0] c1,
                          input logic [11:0] c2, input logic lc);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_a_sign = as; req_b_sign = bs;
        @(negedge clk);
        req_valid = 1'b0;
        chunk_valid = 1'b1; chunk_data = c0; chunk_cout = 1'b0;
        @(negedge clk);
        chunk_data = c1;
        chk("lat_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chunk_data = c2; chunk_cout = lc;
        @(negedge clk);
        chunk_valid = 1'b0; chunk_data = '0; chunk_cout = 1'b0;
        chk("lat_rsp_valid", 32'(rsp_valid), 32'd1);
    endtask

    task automatic handshake();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("hs_busy", 32'(busy), 32'd0);
        chk("hs_rsp_valid", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_op = ADD; req_a_sign = 1'b0; req_b_sign = 1'b0;
        chunk_valid = 1'b0; chunk_data = '0; chunk_cout = 1'b0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_cout", 32'(rsp_cout), 32'd0);
        rst_n = 1'b1;

        // 1. ADD assembly
        run_op(ADD, 1'b0, 1'b0, 12'h234, 12'h001, 12'h000, 1'b0);
        chk("add_result", rsp_result, 32'h0000_1234);
        chk("add_cond", 32'(rsp_cond), 32'd0);
        chk("add_cout", 32'(rsp_cout), 32'd0);
        handshake();

        // 2. EQ / NE
        run_op(EQ, 1'b0, 1'b0, 12'h000, 12'h000, 12'h000, 1'b0);
        chk("eq_zero_cond", 32'(rsp_cond), 32'd1);
        handshake();
        run_op(EQ, 1'b0, 1'b0, 12'h000, 12'h010, 12'h000, 1'b0);
        chk("eq_nz_cond", 32'(rsp_cond), 32'd0);
        chk("eq_nz_result", rsp_result, 32'h0001_0000);
        handshake();
        run_op(NE, 1'b0, 1'b0, 12'h000, 12'h010, 12'h000, 1'b0);
        chk("ne_nz_cond", 32'(rsp_cond), 32'd1);
        handshake();

        // 3. Signed compares
        run_op(LT, 1'b1, 1'b0, 12'h000, 12'h000, 12'h000, 1'b0);
        chk("lt_sign_cond", 32'(rsp_cond), 32'd1);
        handshake();
        run_op(LT, 1'b0, 1'b0, 12'h000, 12'h000, 12'h080, 1'b0);
        chk("lt_res31_cond", 32'(rsp_cond), 32'd1);
        chk("lt_res31_result", rsp_result, 32'h8000_0000);
        handshake();
        run_op(GE, 1'b0, 1'b0, 12'h000, 12'h000, 12'h080, 1'b0);
        chk("ge_res31_cond", 32'(rsp_cond), 32'd0);
        handshake();
        run_op(LT, 1'b0, 1'b1, 12'h000, 12'h000, 12'h080, 1'b0);
        chk("lt_bneg_cond", 32'(rsp_cond), 32'd0);
        handshake();

        // 4. Unsigned compares and last-chunk clipping
        run_op(LTU, 1'b0, 1'b0, 12'h123, 12'h456, 12'h078, 1'b0);
        chk("ltu_cond", 32'(rsp_cond), 32'd1);
        chk("ltu_cout", 32'(rsp_cout), 32'd0);
        handshake();
        run_op(GEU, 1'b0, 1'b0, 12'h123, 12'h456, 12'h078, 1'b1);
        chk("geu_cond", 32'(rsp_cond), 32'd1);
        chk("geu_cout", 32'(rsp_cout), 32'd1);
        chk("geu_result", rsp_result, 32'h7845_6123);
        handshake();
        run_op(ADD, 1'b0, 1'b0, 12'h000, 12'h000, 12'hF80, 1'b0);
        chk("clip_result", rsp_result, 32'h8000_0000);
        handshake();
        run_op(EQ, 1'b0, 1'b0, 12'h000, 12'h000, 12'hF00, 1'b0);
        chk("clip_eq_cond", 32'(rsp_cond), 32'd1);
        chk("clip_eq_result", rsp_result, 32'h0000_0000);
        handshake();

        // 5. Backpressure, ignored request, stray chunk
        run_op(SUB, 1'b0, 1'b0, 12'h111, 12'h222, 12'h033, 1'b1);
        chk("bp_proto_err_pre", 32'(proto_err), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_result", rsp_result, 32'h3322_2111);
            chk("bp_cout", 32'(rsp_cout), 32'd1);
            req_valid = (i == 1);
            req_op = EQ;
            chunk_valid = (i == 2);
            chunk_data = 12'hFFF;
        end
        @(negedge clk);
        req_valid = 1'b0; chunk_valid = 1'b0; chunk_data = '0;
        chk("bp_proto_err", 32'(proto_err), 32'd1);
        chk("bp_result_after", rsp_result, 32'h3322_2111);
        chk("bp_cond_after", 32'(rsp_cond), 32'd0);
        handshake();
        chk("bp_req_ready_idle", 32'(req_ready), 32'd1);
        chk("bp_proto_err_sticky", 32'(proto_err), 32'd1);

        // 6. Reset mid-operation
        @(negedge clk);
        req_valid = 1'b1; req_op = ADD; req_a_sign = 1'b0; req_b_sign = 1'b0;
        @(negedge clk);
        req_valid = 1'b0; chunk_valid = 1'b1; chunk_data = 12'h555;
        @(negedge clk);
        chunk_valid = 1'b0; chunk_data = '0;
        chk("mid_busy_pre", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_proto_err", 32'(proto_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(ADD, 1'b0, 1'b0, 12'hABC, 12'h123, 12'h045, 1'b1);
        chk("post_rst_result", rsp_result, 32'h4512_3ABC);
        chk("post_rst_cout", 32'(rsp_cout), 32'd1);
        chk("post_rst_cond", 32'(rsp_cond), 32'd0);
        handshake();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
